// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue logic.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd1;
  localparam logic [31:0] EXC_DIV     = 32'd2;
  localparam logic [31:0] EXC_TIMEOUT = 32'd3;

  function automatic logic [31:0] exc_code(input op_t op);
    return (op == OP_DIV) ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Watchdog counter: cleared at issue, counts in-flight cycles, flags the last allowed one.
module md_timeout_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned TERMINAL = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = $clog2(TERMINAL + 1);

  logic [CW-1:0] count;

  // done marks the TERMINAL-th enabled cycle since clear; the count then holds.
  assign done = (count == CW'(TERMINAL - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_issue.sv
// Issues mult/div operations to the iterative unit, stalls the pipeline while it
// runs, and produces one writeback (result, unit exception or watchdog timeout).
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_mult,
  input  logic        inst_div,
  input  logic [4:0]  inst_rd,
  input  logic [31:0] inst_operandA,
  input  logic [15:0] inst_operandB,
  output logic [31:0] md_operandA,
  output logic [15:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_inputRDY,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  state_t     state;
  op_t        op;
  logic [4:0] rd_q;
  logic       one_strobe;
  logic       accept;
  logic       in_flight;
  logic       timed_out;

  assign one_strobe = inst_mult ^ inst_div;
  assign accept     = (state == IDLE) && one_strobe;
  assign in_flight  = (state == ISSUE) || (state == BUSY);
  // The strobe cycle itself stalls; reset forces the output low regardless of strobes.
  assign stall      = !reset && ((state != IDLE) || one_strobe);

  md_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (in_flight),
    .done   (timed_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op           <= OP_MULT;
      rd_q         <= '0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_en        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      wb_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (one_strobe) begin
            md_operandA  <= inst_operandA;
            md_operandB  <= inst_operandB;
            rd_q         <= inst_rd;
            op           <= inst_div ? OP_DIV : OP_MULT;
            md_ctrl_MULT <= inst_mult;
            md_ctrl_DIV  <= inst_div;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (timed_out) begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            wb_en        <= 1'b1;
            wb_rd        <= RSTATUS_REG;
            wb_data      <= EXC_TIMEOUT;
            state        <= WB;
          end else if (md_inputRDY) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          // A result arriving on the terminal cycle takes priority over the timeout.
          if (md_resultRDY) begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            if (md_exception) begin
              wb_en   <= 1'b1;
              wb_rd   <= RSTATUS_REG;
              wb_data <= exc_code(op);
            end else begin
              wb_en   <= (rd_q != 5'd0);
              wb_rd   <= rd_q;
              wb_data <= md_result;
            end
            state <= WB;
          end else if (timed_out) begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            wb_en        <= 1'b1;
            wb_rd        <= RSTATUS_REG;
            wb_data      <= EXC_TIMEOUT;
            state        <= WB;
          end
        end
        WB: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: default-timeout instance plus an 8-cycle-timeout instance.
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_mult, inst_div;
  logic [4:0]  inst_rd;
  logic [31:0] inst_operandA;
  logic [15:0] inst_operandB;
  logic [31:0] md_result;
  logic        md_exception, md_inputRDY, md_resultRDY;

  logic [31:0] md_a, md_a8;
  logic [15:0] md_b, md_b8;
  logic        ctrl_m, ctrl_d, stall, wb_en;
  logic        ctrl_m8, ctrl_d8, stall8, wb_en8;
  logic [4:0]  wb_rd, wb_rd8;
  logic [31:0] wb_data, wb_data8;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  multdiv_issue dut (
    .clock(clock), .reset(reset),
    .inst_mult(inst_mult), .inst_div(inst_div), .inst_rd(inst_rd),
    .inst_operandA(inst_operandA), .inst_operandB(inst_operandB),
    .md_operandA(md_a), .md_operandB(md_b),
    .md_ctrl_MULT(ctrl_m), .md_ctrl_DIV(ctrl_d),
    .md_result(md_result), .md_exception(md_exception),
    .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  multdiv_issue #(.TIMEOUT_CYCLES(8)) dut8 (
    .clock(clock), .reset(reset),
    .inst_mult(inst_mult), .inst_div(inst_div), .inst_rd(inst_rd),
    .inst_operandA(inst_operandA), .inst_operandB(inst_operandB),
    .md_operandA(md_a8), .md_operandB(md_b8),
    .md_ctrl_MULT(ctrl_m8), .md_ctrl_DIV(ctrl_d8),
    .md_result(md_result), .md_exception(md_exception),
    .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY),
    .stall(stall8), .wb_en(wb_en8), .wb_rd(wb_rd8), .wb_data(wb_data8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [31:0] o, input logic [31:0] o8,
                            input logic [31:0] exp, input bit use8);
    check(tag, o, exp);
    if (use8) check({tag, "/t8"}, o8, exp);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ":md_a"},    md_a,    32'd0);
    check({tag, ":md_b"},    md_b,    32'd0);
    check({tag, ":ctrl_m"},  ctrl_m,  32'd0);
    check({tag, ":ctrl_d"},  ctrl_d,  32'd0);
    check({tag, ":stall"},   stall,   32'd0);
    check({tag, ":wb_en"},   wb_en,   32'd0);
    check({tag, ":wb_rd"},   wb_rd,   32'd0);
    check({tag, ":wb_data"}, wb_data, 32'd0);
    check({tag, ":ctrl_m8"}, ctrl_m8, 32'd0);
    check({tag, ":stall8"},  stall8,  32'd0);
  endtask

  // Strobe at T, inputRDY at T+1, resultRDY at T+k (k >= 2).
  task automatic do_op(input string tag, input logic m, input logic d, input logic [4:0] rd,
                       input logic [31:0] a, input logic [15:0] b, input int unsigned k,
                       input logic [31:0] res, input logic exc, input logic exp_en,
                       input logic [4:0] exp_rd, input logic [31:0] exp_data);
    bit use8;
    use8 = (k <= 8);
    @(negedge clock);
    inst_mult = m; inst_div = d; inst_rd = rd; inst_operandA = a; inst_operandB = b;
    #1 check_both({tag, ":stall_T"}, stall, stall8, 32'd1, use8);
    for (int unsigned c = 1; c <= k; c++) begin
      @(negedge clock);
      inst_mult = 1'b0; inst_div = 1'b0;
      md_inputRDY  = (c == 1);
      md_resultRDY = (c == k);
      md_result    = (c == k) ? res : 32'h0;
      md_exception = (c == k) && exc;
      #1;
      check_both({tag, ":ctrl_m"}, ctrl_m, ctrl_m8, {31'd0, m}, use8);
      check_both({tag, ":ctrl_d"}, ctrl_d, ctrl_d8, {31'd0, d}, use8);
      check_both({tag, ":stall"},  stall,  stall8,  32'd1, use8);
      check_both({tag, ":wb_en_busy"}, wb_en, wb_en8, 32'd0, use8);
      if (c == 1) begin
        check_both({tag, ":md_a"}, md_a, md_a8, a, use8);
        check_both({tag, ":md_b"}, {16'd0, md_b}, {16'd0, md_b8}, {16'd0, b}, use8);
      end
    end
    @(negedge clock);
    md_inputRDY = 1'b0; md_resultRDY = 1'b0; md_result = 32'h0; md_exception = 1'b0;
    #1;
    check_both({tag, ":wb_ctrl_m"}, ctrl_m, ctrl_m8, 32'd0, use8);
    check_both({tag, ":wb_ctrl_d"}, ctrl_d, ctrl_d8, 32'd0, use8);
    check_both({tag, ":wb_stall"},  stall,  stall8,  32'd1, use8);
    check_both({tag, ":wb_en"},     wb_en,  wb_en8,  {31'd0, exp_en}, use8);
    if (exp_en) begin
      check_both({tag, ":wb_rd"},   wb_rd,   wb_rd8,   exp_rd,   use8);
      check_both({tag, ":wb_data"}, wb_data, wb_data8, exp_data, use8);
    end
    @(negedge clock);
    #1;
    check_both({tag, ":post_wb_en"}, wb_en, wb_en8, 32'd0, use8);
    check_both({tag, ":post_stall"}, stall, stall8, 32'd0, use8);
  endtask

  initial begin
    reset = 1'b1;
    inst_mult = 1'b0; inst_div = 1'b0; inst_rd = '0;
    inst_operandA = '0; inst_operandB = '0;
    md_result = '0; md_exception = 1'b0; md_inputRDY = 1'b0; md_resultRDY = 1'b0;

    #12 check_cleared("reset");
    @(negedge clock);
    reset = 1'b0;

    do_op("mult",  1'b1, 1'b0, 5'd5, 32'd7,   16'hFFFD, 17, 32'hFFFFFFEB, 1'b0, 1'b1, 5'd5,  32'hFFFFFFEB);
    do_op("divexc", 1'b0, 1'b1, 5'd9, 32'd100, 16'd0,     4, 32'h0,       1'b1, 1'b1, 5'd30, 32'd2);

    // Both strobes together: illegal, nothing issues.
    @(negedge clock);
    inst_mult = 1'b1; inst_div = 1'b1; inst_rd = 5'd6; inst_operandA = 32'd1; inst_operandB = 16'd1;
    #1 check("both:stall_T", stall, 32'd0);
    for (int unsigned c = 1; c <= 4; c++) begin
      @(negedge clock);
      inst_mult = 1'b0; inst_div = 1'b0;
      #1;
      check("both:ctrl_m", ctrl_m, 32'd0);
      check("both:ctrl_d", ctrl_d, 32'd0);
      check("both:stall",  stall,  32'd0);
      check("both:wb_en",  wb_en,  32'd0);
    end

    do_op("rd0",   1'b1, 1'b0, 5'd0, 32'd2,   16'd3, 3, 32'd6,  1'b0, 1'b0, 5'd0, 32'd0);
    do_op("div8",  1'b0, 1'b1, 5'd3, 32'd100, 16'd7, 8, 32'd14, 1'b0, 1'b1, 5'd3, 32'd14);

    // Timeout: inputRDY only; dut8 aborts after 8 cycles, dut after 64.
    @(negedge clock);
    inst_mult = 1'b1; inst_rd = 5'd12; inst_operandA = 32'd5; inst_operandB = 16'd6;
    #1 check("tmo:stall_T", stall8, 32'd1);
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clock);
      inst_mult = 1'b0;
      md_inputRDY = (c == 1);
      #1 check("tmo:ctrl_m8", ctrl_m8, 32'd1);
    end
    @(negedge clock);
    md_inputRDY = 1'b0;
    #1;
    check("tmo:ctrl_m8_low", ctrl_m8,  32'd0);
    check("tmo:wb_en8",      wb_en8,   32'd1);
    check("tmo:wb_rd8",      wb_rd8,   32'd30);
    check("tmo:wb_data8",    wb_data8, 32'd3);
    check("tmo:ctrl_m_64",   ctrl_m,   32'd1);
    @(negedge clock);
    #1;
    check("tmo:post_wb_en8", wb_en8, 32'd0);
    check("tmo:post_stall8", stall8, 32'd0);
    for (int unsigned c = 11; c <= 64; c++) begin
      @(negedge clock);
      #1;
      if (c == 64) check("tmo64:ctrl_m_last", ctrl_m, 32'd1);
    end
    @(negedge clock);
    #1;
    check("tmo64:ctrl_m_low", ctrl_m,  32'd0);
    check("tmo64:wb_en",      wb_en,   32'd1);
    check("tmo64:wb_rd",      wb_rd,   32'd30);
    check("tmo64:wb_data",    wb_data, 32'd3);
    @(negedge clock);
    #1 check("tmo64:post_stall", stall, 32'd0);

    // Reset asserted mid-cycle while BUSY.
    @(negedge clock);
    inst_div = 1'b1; inst_rd = 5'd4; inst_operandA = 32'd100; inst_operandB = 16'd3;
    @(negedge clock);
    inst_div = 1'b0; md_inputRDY = 1'b1;
    @(negedge clock);
    md_inputRDY = 1'b0;
    #1 check("rstbusy:ctrl_d_before", ctrl_d, 32'd1);
    #2 reset = 1'b1;
    #1 check_cleared("rstbusy");
    @(negedge clock);
    reset = 1'b0;
    md_resultRDY = 1'b1; md_result = 32'd33;
    for (int unsigned c = 1; c <= 4; c++) begin
      @(negedge clock);
      md_resultRDY = 1'b0; md_result = 32'd0;
      #1;
      check("rstbusy:wb_en", wb_en,  32'd0);
      check("rstbusy:ctrl",  ctrl_d, 32'd0);
      check("rstbusy:stall", stall,  32'd0);
    end

    do_op("after_rst", 1'b1, 1'b0, 5'd7, 32'd3, 16'd4, 2, 32'd12, 1'b0, 1'b1, 5'd7, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Processor-side initiator for the iterative multiply/divide unit. Accepts one-cycle mult/div strobes with operands and destination register from the execute stage, and drives the unit's control, operand and ready handshake. Stalls the pipeline until the result returns, then emits a single register-file writeback. Unit exceptions and a watchdog timeout are routed to the status register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles with a control line asserted before the operation is aborted.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- inst_mult  in  1  one-cycle strobe: issue multiply
- inst_div  in  1  one-cycle strobe: issue divide
- inst_rd  in  5  destination register of the strobed instruction
- inst_operandA  in  32  dividend / multiplicand
- inst_operandB  in  16  divisor / multiplier
- md_operandA  out  32  latched operand A to unit
- md_operandB  out  16  latched operand B to unit
- md_ctrl_MULT  out  1  held high for the whole multiply operation
- md_ctrl_DIV  out  1  held high for the whole divide operation
- md_result  in  32  unit result; valid only while its control line is high
- md_exception  in  1  unit exception; sampled with md_resultRDY
- md_inputRDY  in  1  unit has accepted operands
- md_resultRDY  in  1  unit result valid
- stall  out  1  freeze upstream pipeline
- wb_en  out  1  one-cycle register-file write enable
- wb_rd  out  5  write address
- wb_data  out  32  write data

## Operation
- States: IDLE, ISSUE, BUSY, WB.
- IDLE:
  - Exactly one strobe high: latch operands, rd and op type; go to ISSUE.
  - Both strobes high: illegal; ignored, no issue, stall stays 0.
  - Neither strobe high: stay in IDLE.
- ISSUE: assert the selected md_ctrl; operands held stable. When md_inputRDY=1, go to BUSY.
- BUSY: control still high. When md_resultRDY=1, capture md_result and md_exception into registers; go to WB.
- WB: both control lines low; wb_en=1 for exactly one cycle; go to IDLE.
- Writeback data:
  - No exception: wb_rd=latched rd, wb_data=result.
  - Exception: wb_rd=30, wb_data=1 for mult, 2 for div.
  - Timeout: wb_rd=30, wb_data=3.
  - rd=0 with no exception: wb_en stays 0; WB state still entered.
- Timeout counter:
  - Clears on IDLE→ISSUE; increments every ISSUE/BUSY cycle.
  - On the TIMEOUT_CYCLES-th such cycle without md_resultRDY, go to WB with timeout.
  - md_resultRDY in that same cycle wins over timeout.
- Strobes outside IDLE are ignored.
- stall = (state≠IDLE) | (IDLE & exactly one strobe): combinational, so the strobe cycle itself stalls.
- Reset, including mid-operation: all outputs 0 and state IDLE immediately. No writeback is produced for the aborted operation.

## Timing
- Strobe at cycle T; ISSUE at T+1, control high from T+1.
- inputRDY at T+1 and resultRDY at T+k gives: WB at T+k+1, control low at T+k+1, IDLE at T+k+2.
- Minimum operation (k=2): stall high T..T+3, wb_en at T+3.
- A new strobe is accepted at T+k+2 at the earliest.
- md_result and md_exception are sampled only in BUSY, in the md_resultRDY cycle.
- wb_* outputs are registered.

## Structure
- Package multdiv_pkg contains:
  - state enum
  - RSTATUS_REG=30
  - EXC_MULT=1, EXC_DIV=2, EXC_TIMEOUT=3
- The timeout counter is a natural sub-module, md_timeout_counter (clear, enable, terminal-count output). The FSM stays in multdiv_issue.

## Test plan
- Reset asserted mid-cycle -> all outputs 0 immediately; stall=0.
- inst_mult, A=7, B=0xFFFD, rd=5; model inputRDY at T+1, resultRDY at T+17 with 0xFFFFFFEB -> md_ctrl_MULT high T+1..T+17; wb_en at T+18 with wb_rd=5, wb_data=0xFFFFFFEB; stall low at T+19.
- inst_div, A=100, B=0; model raises md_exception with resultRDY -> wb_rd=30, wb_data=2; no write to rd.
- inst_mult and inst_div both high -> no control asserted, stall=0, wb_en never high. Separately, inst_mult with rd=0 -> operation runs, wb_en stays 0.
- TIMEOUT_CYCLES=8; model gives inputRDY but never resultRDY -> control high exactly 8 cycles, then wb_en with wb_rd=30, wb_data=3.
- Reset asserted during BUSY -> control low at once; no writeback after release; next strobe issues normally.
